cachepool_refill_arbiter: RTL and testbench
===========================================

// Module: cachepool_refill_arbiter
// PURPOSE
//  Shares one L2 refill port between NumReq L1 cache controllers. Round-robin arbitration.
//  Write bursts hold the grant until their last beat. Accepted requests are tagged with the requester index.
//  Returned responses are routed back to the requester by that tag. Sits between cache controllers and the L2 xbar.
// PARAMETERS
//  NumReq         4    number of cache controllers (requesters)
//  BurstBeats     4    beats per line (L1LineWidth/RefillDataWidth)
//  MaxOutstanding 8    max in-flight transactions per requester
//  AddrWidth      32   refill address width
//  DataWidth      128  refill data width; strobe is DataWidth/8
//  InfoWidth      16   opaque cache_info bits, passed through unchanged
//  IdW            $clog2(NumReq) requester tag width (min 1)
// PORTS
//  clk_i          in   1                  clock
//  rst_i          in   1                  synchronous reset, active-high
//  req_valid_i    in   NumReq             per-requester request valid
//  req_ready_o    out  NumReq             per-requester request ready
//  req_addr_i     in   NumReq*AddrWidth   line address
//  req_write_i    in   NumReq             1=write beat, 0=line read
//  req_last_i     in   NumReq             last beat of write burst (ignored for reads)
//  req_wdata_i    in   NumReq*DataWidth   write data
//  req_wstrb_i    in   NumReq*DataWidth/8 write strobe
//  req_info_i     in   NumReq*InfoWidth   cache info
//  out_valid_o    out  1                  L2 request valid
//  out_ready_i    in   1                  L2 request ready
//  out_addr_o/out_write_o/out_last_o/out_wdata_o/out_wstrb_o/out_info_o  out  as above  muxed request
//  out_id_o       out  IdW                granted requester index
//  rsp_valid_i    in   1                  L2 response valid
//  rsp_ready_o    out  1                  L2 response ready
//  rsp_id_i       in   IdW                response tag (echo of out_id_o)
//  rsp_last_i     in   1                  final beat of this transaction's response
//  rsp_data_i     in   DataWidth          read data
//  rsp_info_i     in   InfoWidth          echoed info
//  rsp_valid_o    out  NumReq             per-requester response valid
//  rsp_ready_i    in   NumReq             per-requester response ready
//  rsp_last_o/rsp_data_o/rsp_info_o  out  1/DataWidth/InfoWidth  broadcast response payload
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, all outstanding counters=0, hold=0.
//  All valid/ready outputs are 0 during reset.
//  Eligible requester: req_valid_i[i] && cnt[i] < MaxOutstanding.
//  IDLE: grant the first eligible index at or after rr_ptr, cyclically.
//   - Grant is combinational; 0-cycle request latency.
//   - If none is eligible, out_valid_o=0.
//  Hold rule: if out_valid_o && !out_ready_i, the register hold=1 freezes the grant next cycle.
//   - No re-arbitration until the handshake completes.
//   - Requesters must keep valid and payload stable.
//  Handshake: req_ready_o[g] = out_ready_i for the granted g only; all others are 0.
//  Read accepted: cnt[g]++; rr_ptr=(g+1)%NumReq; stay IDLE.
//  Write beat accepted, !req_last_i: go to BURST(g).
//  Write beat accepted, last: cnt[g]++; rr_ptr=(g+1)%NumReq.
//  BURST(g): grant locked to g, regardless of other valids or counters.
//   - Accepted beat with last=1 -> cnt[g]++; rr_ptr=(g+1)%NumReq; go to IDLE.
//   - A read from g while in BURST is a protocol error (assertion).
//  Response path (combinational):
//   - rsp_valid_o[rsp_id_i] = rsp_valid_i; rsp_ready_o = rsp_ready_i[rsp_id_i].
//   - Payload is broadcast to all requesters.
//   - rsp_id_i >= NumReq: assertion error; response sunk (rsp_ready_o=1, no rsp_valid_o).
//  Response beat counts:
//   - Reads return BurstBeats beats, last flagged on the final beat.
//   - Writes return 1 beat with last=1.
//   - A response handshake with rsp_last_i=1 decrements cnt[rsp_id_i].
//  Counter arithmetic: width $clog2(MaxOutstanding+1).
//   - Increment and decrement on the same requester in the same cycle -> unchanged.
//   - Decrement at 0 is an assertion error; the counter saturates at 0.
//  Reset mid-burst or mid-hold: FSM returns to IDLE and counters clear.
//   - In-flight L2 responses must be flushed externally.
// TESTING
//  1. All 4 requesters issue a read in the same cycle, out_ready_i=1 -> grants 0,1,2,3 on consecutive cycles; out_id_o=0..3.
//  2. Req1 4-beat write burst, req2 read valid throughout -> beats 1a..1d back-to-back, then req2 granted; cnt[1]=1.
//  3. out_ready_i=0 for 3 cycles while req0 is granted, then req3 raises valid -> grant stays on 0 until the handshake.
//  4. Req0 issues 8 reads with no responses -> 9th read blocked (req_ready_o[0]=0); req1 still granted; 1 last-response -> req0 unblocked.
//  5. Response id=2, 4 beats, rsp_ready_i[2] toggling -> only rsp_valid_o[2] asserted; cnt[2] drops at beat 4 only.
//  6. rst_i pulse after beat 2 of a req3 burst -> next cycle IDLE, rr_ptr=0; req0 granted first if valid.

Source files
------------

// File: rtl/cachepool_refill_arbiter.sv
// Refill port arbiter: shares one L2 refill port between NumReq L1 cache
// controllers with round-robin grants, write-burst locking, per-requester
// outstanding limits and tag-based response routing.
module cachepool_refill_arbiter #(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned BurstBeats     = 4,
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 128,
    parameter int unsigned InfoWidth      = 16,
    parameter int unsigned IdW            = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumReq-1:0]               req_valid_i,
    output logic [NumReq-1:0]               req_ready_o,
    input  logic [NumReq*AddrWidth-1:0]     req_addr_i,
    input  logic [NumReq-1:0]               req_write_i,
    input  logic [NumReq-1:0]               req_last_i,
    input  logic [NumReq*DataWidth-1:0]     req_wdata_i,
    input  logic [NumReq*DataWidth/8-1:0]   req_wstrb_i,
    input  logic [NumReq*InfoWidth-1:0]     req_info_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [AddrWidth-1:0]            out_addr_o,
    output logic                            out_write_o,
    output logic                            out_last_o,
    output logic [DataWidth-1:0]            out_wdata_o,
    output logic [DataWidth/8-1:0]          out_wstrb_o,
    output logic [InfoWidth-1:0]            out_info_o,
    output logic [IdW-1:0]                  out_id_o,
    input  logic                            rsp_valid_i,
    output logic                            rsp_ready_o,
    input  logic [IdW-1:0]                  rsp_id_i,
    input  logic                            rsp_last_i,
    input  logic [DataWidth-1:0]            rsp_data_i,
    input  logic [InfoWidth-1:0]            rsp_info_i,
    output logic [NumReq-1:0]               rsp_valid_o,
    input  logic [NumReq-1:0]               rsp_ready_i,
    output logic                            rsp_last_o,
    output logic [DataWidth-1:0]            rsp_data_o,
    output logic [InfoWidth-1:0]            rsp_info_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned CntW      = $clog2(MaxOutstanding + 1);
    localparam int unsigned BeatW     = $clog2(BurstBeats + 1);
    localparam logic [IdW:0] NumReqW  = (IdW + 1)'(NumReq);

    typedef enum logic {IDLE, BURST} state_e;

    state_e                 state_q, state_d;
    logic [IdW-1:0]         burst_id_q;
    logic [IdW-1:0]         rr_ptr_q;
    logic                   hold_q;
    logic [IdW-1:0]         hold_id_q;
    logic [NumReq-1:0]      eligible;
    logic                   rr_found;
    logic [IdW-1:0]         rr_id;
    logic                   gnt_valid;
    logic [IdW-1:0]         gnt_id;
    logic [IdW-1:0]         next_ptr;
    logic                   accept;
    logic                   txn_done;
    logic                   burst_start;
    logic                   rsp_in_range;
    logic                   rsp_done;

    logic [AddrWidth-1:0]   addr_arr  [NumReq];
    logic [DataWidth-1:0]   wdata_arr [NumReq];
    logic [StrbWidth-1:0]   wstrb_arr [NumReq];
    logic [InfoWidth-1:0]   info_arr  [NumReq];

    // Per-requester payload views, outstanding counters and response beat tracking
    for (genvar i = 0; i < NumReq; i++) begin : g_req
        logic [CntW-1:0]  cnt;
        logic [BeatW-1:0] beats;
        logic             inc;
        logic             dec;
        logic             rsp_hs;

        assign addr_arr[i]  = req_addr_i[i*AddrWidth +: AddrWidth];
        assign wdata_arr[i] = req_wdata_i[i*DataWidth +: DataWidth];
        assign wstrb_arr[i] = req_wstrb_i[i*StrbWidth +: StrbWidth];
        assign info_arr[i]  = req_info_i[i*InfoWidth +: InfoWidth];

        assign inc         = txn_done && (gnt_id == IdW'(i));
        assign dec         = rsp_done && (rsp_id_i == IdW'(i));
        assign rsp_hs      = rsp_valid_i && rsp_ready_o && rsp_in_range && (rsp_id_i == IdW'(i));
        assign eligible[i] = req_valid_i[i] && (cnt < CntW'(MaxOutstanding));

        // Outstanding count: simultaneous inc/dec cancels, decrement saturates at zero
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt <= '0;
            end else if (inc && !dec) begin
                cnt <= cnt + 1'b1;
            end else if (dec && !inc && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
        end

        // Count non-final response beats so an overlong response can be flagged
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                beats <= '0;
            end else if (rsp_hs) begin
                beats <= rsp_last_i ? '0 : beats + 1'b1;
            end
        end

        a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
            (dec && !inc) |-> (cnt != '0));
        a_beat_limit: assert property (@(posedge clk_i) disable iff (rst_i)
            (rsp_hs && !rsp_last_i) |-> (beats < BeatW'(BurstBeats - 1)));
    end

    // Round-robin search: first eligible requester at or after the pointer
    always_comb begin : p_rr
        int unsigned idx;
        idx      = 0;
        rr_found = 1'b0;
        rr_id    = '0;
        for (int k = 0; k < NumReq; k++) begin
            idx = (int'(rr_ptr_q) + k) % NumReq;
            if (!rr_found && eligible[idx]) begin
                rr_found = 1'b1;
                rr_id    = IdW'(idx);
            end
        end
    end

    // Grant selection: burst lock beats a held grant, which beats fresh arbitration
    always_comb begin
        gnt_id    = rr_id;
        gnt_valid = rr_found;
        if (state_q == BURST) begin
            gnt_id    = burst_id_q;
            gnt_valid = req_valid_i[burst_id_q];
        end else if (hold_q) begin
            gnt_id    = hold_id_q;
            gnt_valid = req_valid_i[hold_id_q];
        end
        if (rst_i) begin
            gnt_valid = 1'b0;
        end
    end

    assign out_valid_o = gnt_valid;
    assign out_id_o    = gnt_id;
    assign out_addr_o  = addr_arr[gnt_id];
    assign out_write_o = req_write_i[gnt_id];
    assign out_last_o  = req_last_i[gnt_id];
    assign out_wdata_o = wdata_arr[gnt_id];
    assign out_wstrb_o = wstrb_arr[gnt_id];
    assign out_info_o  = info_arr[gnt_id];

    assign accept      = gnt_valid && out_ready_i;
    assign txn_done    = accept && (!out_write_o || out_last_o);
    assign burst_start = accept && out_write_o && !out_last_o;
    assign next_ptr    = (gnt_id == IdW'(NumReq - 1)) ? '0 : gnt_id + 1'b1;

    // Only the granted requester sees the L2 ready
    always_comb begin
        req_ready_o = '0;
        if (gnt_valid) begin
            req_ready_o[gnt_id] = out_ready_i;
        end
    end

    // FSM next state: a non-final write beat locks the port until the last beat
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (burst_start) state_d = BURST;
            BURST:   if (txn_done)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Arbitration bookkeeping: pointer advances on completed transactions, grant freezes on stall
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            hold_q     <= 1'b0;
            hold_id_q  <= '0;
            burst_id_q <= '0;
        end else begin
            hold_q    <= gnt_valid && !out_ready_i;
            hold_id_q <= gnt_id;
            if ((state_q == IDLE) && burst_start) begin
                burst_id_q <= gnt_id;
            end
            if (txn_done) begin
                rr_ptr_q <= next_ptr;
            end
        end
    end

    assign rsp_in_range = ({1'b0, rsp_id_i} < NumReqW);
    assign rsp_done     = rsp_valid_i && rsp_ready_o && rsp_last_i && rsp_in_range;
    assign rsp_last_o   = rsp_last_i;
    assign rsp_data_o   = rsp_data_i;
    assign rsp_info_o   = rsp_info_i;

    // Response routing by tag; unknown tags are sunk without reaching any requester
    always_comb begin
        rsp_valid_o = '0;
        rsp_ready_o = 1'b0;
        if (!rst_i) begin
            if (rsp_in_range) begin
                rsp_valid_o[rsp_id_i] = rsp_valid_i;
                rsp_ready_o           = rsp_ready_i[rsp_id_i];
            end else begin
                rsp_ready_o = 1'b1;
            end
        end
    end

    a_burst_write_only: assert property (@(posedge clk_i) disable iff (rst_i)
        ((state_q == BURST) && out_valid_o) |-> out_write_o);
    a_rsp_id_range: assert property (@(posedge clk_i) disable iff (rst_i)
        rsp_valid_i |-> rsp_in_range);

endmodule

// File: tb/tb_cachepool_refill_arbiter.sv
// Testbench for cachepool_refill_arbiter: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a transaction-level model.
module tb_cachepool_refill_arbiter;

    localparam int N   = 4;
    localparam int BB  = 4;
    localparam int MO  = 8;
    localparam int AW  = 32;
    localparam int DW  = 128;
    localparam int IW  = 16;
    localparam int IDW = 2;

    typedef struct {
        logic           rst;
        logic [N-1:0]   rv;
        logic [N-1:0]   wr;
        logic [N-1:0]   lst;
        logic           ordy;
        logic           pv;
        logic [IDW-1:0] pid;
        logic           plast;
        logic [N-1:0]   prdy;
        logic           ov;
        logic [IDW-1:0] oid;
        logic [N-1:0]   rrdy;
        logic [N-1:0]   pvo;
        logic           pro;
    } vec_t;

    typedef struct {
        int id;
        int beats;
    } txn_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*AW-1:0]    req_addr;
    logic [N-1:0]       req_write;
    logic [N-1:0]       req_last;
    logic [N*DW-1:0]    req_wdata;
    logic [N*DW/8-1:0]  req_wstrb;
    logic [N*IW-1:0]    req_info;
    logic               out_valid;
    logic               out_ready;
    logic [AW-1:0]      out_addr;
    logic               out_write;
    logic               out_last;
    logic [DW-1:0]      out_wdata;
    logic [DW/8-1:0]    out_wstrb;
    logic [IW-1:0]      out_info;
    logic [IDW-1:0]     out_id;
    logic               rsp_valid_in;
    logic               rsp_ready_out;
    logic [IDW-1:0]     rsp_id;
    logic               rsp_last_in;
    logic [DW-1:0]      rsp_data_in;
    logic [IW-1:0]      rsp_info_in;
    logic [N-1:0]       rsp_valid_out;
    logic [N-1:0]       rsp_ready_in;
    logic               rsp_last_out;
    logic [DW-1:0]      rsp_data_out;
    logic [IW-1:0]      rsp_info_out;

    logic [AW-1:0]      pay_addr  [N];
    logic [DW-1:0]      pay_wdata [N];
    logic [DW/8-1:0]    pay_wstrb [N];
    logic [IW-1:0]      pay_info  [N];
    logic               pay_last  [N];

    int checks = 0;
    int errors = 0;

    // Transaction-level model state
    txn_t txq[$];
    int   m_ptr;
    bit   m_burst;
    int   m_owner;
    bit   m_held;
    int   m_hold_id;

    // Random traffic driver state
    bit   presenting [N];
    bit   is_wr      [N];
    int   rem        [N];
    bit   rsp_pres;
    int   rsp_beat;

    vec_t vecs[$];

    always #5 clk = ~clk;

    cachepool_refill_arbiter #(
        .NumReq(N), .BurstBeats(BB), .MaxOutstanding(MO),
        .AddrWidth(AW), .DataWidth(DW), .InfoWidth(IW), .IdW(IDW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_write_i(req_write), .req_last_i(req_last), .req_wdata_i(req_wdata),
        .req_wstrb_i(req_wstrb), .req_info_i(req_info),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_addr_o(out_addr),
        .out_write_o(out_write), .out_last_o(out_last), .out_wdata_o(out_wdata),
        .out_wstrb_o(out_wstrb), .out_info_o(out_info), .out_id_o(out_id),
        .rsp_valid_i(rsp_valid_in), .rsp_ready_o(rsp_ready_out), .rsp_id_i(rsp_id),
        .rsp_last_i(rsp_last_in), .rsp_data_i(rsp_data_in), .rsp_info_i(rsp_info_in),
        .rsp_valid_o(rsp_valid_out), .rsp_ready_i(rsp_ready_in), .rsp_last_o(rsp_last_out),
        .rsp_data_o(rsp_data_out), .rsp_info_o(rsp_info_out)
    );

    function automatic vec_t mk(input logic r, input logic [N-1:0] rv, input logic [N-1:0] wr,
                                input logic [N-1:0] lst, input logic ordy, input logic pv,
                                input logic [IDW-1:0] pid, input logic plast, input logic [N-1:0] prdy,
                                input logic ov, input logic [IDW-1:0] oid, input logic [N-1:0] rrdy,
                                input logic [N-1:0] pvo, input logic pro);
        vec_t v;
        v.rst = r;   v.rv = rv;     v.wr = wr;     v.lst = lst;   v.ordy = ordy;
        v.pv = pv;   v.pid = pid;   v.plast = plast; v.prdy = prdy;
        v.ov = ov;   v.oid = oid;   v.rrdy = rrdy; v.pvo = pvo;   v.pro = pro;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pack_payload();
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]         = pay_addr[i];
            req_wdata[i*DW +: DW]        = pay_wdata[i];
            req_wstrb[i*(DW/8) +: DW/8]  = pay_wstrb[i];
            req_info[i*IW +: IW]         = pay_info[i];
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        rst          = v.rst;
        req_valid    = v.rv;
        req_write    = v.wr;
        req_last     = v.lst;
        out_ready    = v.ordy;
        rsp_valid_in = v.pv;
        rsp_id       = v.pid;
        rsp_last_in  = v.plast;
        rsp_ready_in = v.prdy;
        pack_payload();
    endtask

    task automatic check_output(input logic ov, input logic [IDW-1:0] oid, input logic [N-1:0] rrdy,
                                input logic [N-1:0] pvo, input logic pro);
        check("out_valid", out_valid, ov);
        if (ov) begin
            check("out_id", out_id, oid);
            check("out_addr", out_addr, pay_addr[oid]);
            check("out_wdata", out_wdata, pay_wdata[oid]);
            check("out_info", out_info, pay_info[oid]);
            check("out_write", out_write, req_write[oid]);
            check("out_last", out_last, req_last[oid]);
        end
        check("req_ready", req_ready, rrdy);
        check("rsp_valid_o", rsp_valid_out, pvo);
        check("rsp_ready_o", rsp_ready_out, pro);
        check("rsp_data_o", rsp_data_out, rsp_data_in);
    endtask

    task automatic run_vec(input vec_t v);
        apply_stimulus(v);
        #1;
        check_output(v.ov, v.oid, v.rrdy, v.pvo, v.pro);
        @(posedge clk);
        #1;
    endtask

    function automatic int outstanding(input int id);
        int n = 0;
        foreach (txq[k]) if (txq[k].id == id) n++;
        return n;
    endfunction

    // Expected grant from the arbitration rules, stated over transactions
    function automatic void model_grant(output logic v, output logic [IDW-1:0] g);
        v = 1'b0;
        g = '0;
        if (m_burst) begin
            g = IDW'(m_owner);
            v = req_valid[m_owner];
        end else if (m_held) begin
            g = IDW'(m_hold_id);
            v = req_valid[m_hold_id];
        end else begin
            for (int k = 0; k < N; k++) begin
                int idx = (m_ptr + k) % N;
                if (!v && req_valid[idx] && (outstanding(idx) < MO)) begin
                    v = 1'b1;
                    g = IDW'(idx);
                end
            end
        end
    endfunction

    task automatic random_cycle();
        logic           ev;
        logic [IDW-1:0] eg;
        logic [N-1:0]   exp_rrdy;
        logic [N-1:0]   exp_pvo;
        logic           exp_pro;
        bit             done;
        txn_t           t;

        for (int i = 0; i < N; i++) begin
            if (!presenting[i]) begin
                if (rem[i] == 0 && $urandom_range(0, 9) < 3) begin
                    is_wr[i] = $urandom_range(0, 1) == 1;
                    rem[i]   = is_wr[i] ? BB : 1;
                end
                if (rem[i] != 0 && $urandom_range(0, 9) < 6) begin
                    presenting[i] = 1'b1;
                    pay_addr[i]   = $urandom;
                    pay_wdata[i]  = {$urandom, $urandom, $urandom, $urandom};
                    pay_wstrb[i]  = {$urandom, $urandom};
                    pay_info[i]   = IW'($urandom);
                    pay_last[i]   = is_wr[i] ? (rem[i] == 1) : ($urandom_range(0, 1) == 1);
                end
            end
            req_valid[i] = presenting[i];
            req_write[i] = is_wr[i];
            req_last[i]  = pay_last[i];
        end
        pack_payload();

        if (!rsp_pres && txq.size() > 0 && $urandom_range(0, 9) < 6) begin
            rsp_pres    = 1'b1;
            rsp_data_in = {$urandom, $urandom, $urandom, $urandom};
            rsp_info_in = IW'($urandom);
        end
        rsp_valid_in = rsp_pres;
        rsp_id       = (txq.size() > 0) ? IDW'(txq[0].id) : IDW'($urandom_range(0, N - 1));
        rsp_last_in  = rsp_pres && (rsp_beat + 1 == txq[0].beats);
        rsp_ready_in = N'($urandom);
        out_ready    = $urandom_range(0, 9) < 7;

        model_grant(ev, eg);
        exp_rrdy = '0;
        if (ev && out_ready) exp_rrdy[eg] = 1'b1;
        exp_pvo = '0;
        if (rsp_valid_in) exp_pvo[rsp_id] = 1'b1;
        exp_pro = rsp_ready_in[rsp_id];

        #1;
        check_output(ev, eg, exp_rrdy, exp_pvo, exp_pro);

        if (ev && out_ready) begin
            done = !is_wr[eg] || pay_last[eg];
            presenting[eg] = 1'b0;
            rem[eg]--;
            if (done) begin
                t.id    = int'(eg);
                t.beats = is_wr[eg] ? 1 : BB;
                txq.push_back(t);
                m_ptr   = (int'(eg) + 1) % N;
                m_burst = 1'b0;
            end else begin
                m_burst = 1'b1;
                m_owner = int'(eg);
            end
        end
        m_held    = ev && !out_ready;
        m_hold_id = int'(eg);
        if (rsp_valid_in && exp_pro) begin
            rsp_pres = 1'b0;
            if (rsp_last_in) begin
                void'(txq.pop_front());
                rsp_beat = 0;
            end else begin
                rsp_beat++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; req_write = '0; req_last = '0; out_ready = 1'b0;
        rsp_valid_in = 1'b0; rsp_id = '0; rsp_last_in = 1'b0; rsp_ready_in = '0;
        rsp_data_in = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        rsp_info_in = 16'h5a5a;
        for (int i = 0; i < N; i++) begin
            pay_addr[i]  = 32'h1000_0000 + 32'(i * 64);
            pay_wdata[i] = {4{32'hd00d_0000 + 32'(i)}};
            pay_wstrb[i] = 16'hff00 | 16'(i);
            pay_info[i]  = 16'h0a00 + 16'(i);
            pay_last[i]  = 1'b0;
        end
        pack_payload();
        @(posedge clk);
        #1;

        // Reset, simultaneous reads, write burst lock, held grant, response routing
        vecs.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000, 1, 1, 2'd1, 1, 4'b0010, 0, 2'd0, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 1, 0, 2'd0, 0, 4'b0000, 1, 2'd0, 4'b0001, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b1110, 4'b0000, 4'b0000, 1, 0, 2'd0, 0, 4'b0000, 1, 2'd1, 4'b0010, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b1100, 4'b0000, 4'b0000, 1, 0, 2'd0, 0, 4'b0000, 1, 2'd2, 4'b0100, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b1000, 4'b0000, 4'b0000, 1, 0, 2'd0, 0, 4'b0000, 1, 2'd3, 4'b1000, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0110, 4'b0010, 4'b0000, 1, 0, 2'd0, 0, 4'b0000, 1, 2'd1, 4'b0010, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0110, 4'b0010, 4'b0000, 1, 0, 2'd0, 0, 4'b0000, 1, 2'd1, 4'b0010, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0110, 4'b0010, 4'b0000, 1, 0, 2'd0, 0, 4'b0000, 1, 2'd1, 4'b0010, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0110, 4'b0010, 4'b0010, 1, 0, 2'd0, 0, 4'b0000, 1, 2'd1, 4'b0010, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0000, 1, 0, 2'd0, 0, 4'b0000, 1, 2'd2, 4'b0100, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 2'd0, 0, 4'b0000, 1, 2'd0, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b1001, 4'b0000, 4'b0000, 0, 0, 2'd0, 0, 4'b0000, 1, 2'd0, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b1001, 4'b0000, 4'b0000, 0, 0, 2'd0, 0, 4'b0000, 1, 2'd0, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b1001, 4'b0000, 4'b0000, 1, 0, 2'd0, 0, 4'b0000, 1, 2'd0, 4'b0001, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b1000, 4'b0000, 4'b0000, 1, 0, 2'd0, 0, 4'b0000, 1, 2'd3, 4'b1000, 4'b0000, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 2'd2, 0, 4'b0100, 0, 2'd0, 4'b0000, 4'b0100, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 2'd2, 0, 4'b0000, 0, 2'd0, 4'b0000, 4'b0100, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 2'd2, 0, 4'b0100, 0, 2'd0, 4'b0000, 4'b0100, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 2'd2, 0, 4'b0100, 0, 2'd0, 4'b0000, 4'b0100, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 2'd2, 1, 4'b0000, 0, 2'd0, 4'b0000, 4'b0100, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 2'd2, 1, 4'b0100, 0, 2'd0, 4'b0000, 4'b0100, 1));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0000, 1, 1, 2'd2, 1, 4'b0100, 1, 2'd2, 4'b0100, 4'b0100, 1));
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Outstanding limit: ninth read from req0 blocks, req1 still served, a last beat unblocks
        run_vec(mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd0, 0, 4'b0000, 0, 2'd0, 4'b0000, 4'b0000, 0));
        for (int i = 0; i < MO; i++)
            run_vec(mk(0, 4'b0001, 4'b0000, 4'b0000, 1, 0, 2'd0, 0, 4'b0000, 1, 2'd0, 4'b0001, 4'b0000, 0));
        run_vec(mk(0, 4'b0011, 4'b0000, 4'b0000, 1, 0, 2'd0, 0, 4'b0000, 1, 2'd1, 4'b0010, 4'b0000, 0));
        run_vec(mk(0, 4'b0001, 4'b0000, 4'b0000, 1, 0, 2'd0, 0, 4'b0000, 0, 2'd0, 4'b0000, 4'b0000, 0));
        run_vec(mk(0, 4'b0001, 4'b0000, 4'b0000, 1, 1, 2'd0, 1, 4'b0001, 0, 2'd0, 4'b0000, 4'b0001, 1));
        run_vec(mk(0, 4'b0001, 4'b0000, 4'b0000, 1, 0, 2'd0, 0, 4'b0000, 1, 2'd0, 4'b0001, 4'b0000, 0));

        // Reset in the middle of a req3 burst drops the lock and the pointer
        run_vec(mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd0, 0, 4'b0000, 0, 2'd0, 4'b0000, 4'b0000, 0));
        run_vec(mk(0, 4'b1000, 4'b1000, 4'b0000, 1, 0, 2'd0, 0, 4'b0000, 1, 2'd3, 4'b1000, 4'b0000, 0));
        run_vec(mk(0, 4'b1001, 4'b1000, 4'b0000, 1, 0, 2'd0, 0, 4'b0000, 1, 2'd3, 4'b1000, 4'b0000, 0));
        run_vec(mk(1, 4'b1001, 4'b1000, 4'b0000, 1, 1, 2'd1, 0, 4'b0010, 0, 2'd0, 4'b0000, 4'b0000, 0));
        run_vec(mk(0, 4'b1001, 4'b1000, 4'b0000, 1, 0, 2'd0, 0, 4'b0000, 1, 2'd0, 4'b0001, 4'b0000, 0));

        // Randomized traffic against the transaction-level model
        run_vec(mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'd0, 0, 4'b0000, 0, 2'd0, 4'b0000, 4'b0000, 0));
        rst = 1'b0;
        txq.delete();
        m_ptr = 0; m_burst = 1'b0; m_owner = 0; m_held = 1'b0; m_hold_id = 0;
        rsp_pres = 1'b0; rsp_beat = 0;
        for (int i = 0; i < N; i++) begin
            presenting[i] = 1'b0; is_wr[i] = 1'b0; rem[i] = 0; pay_last[i] = 1'b0;
        end
        for (int c = 0; c < 2000; c++) random_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
